// File: rtl/nibble_ram_responder.sv
// nibble_ram_responder: nibble-serial RAM slave, one address in and one word out per frame
module nibble_ram_responder #(
  parameter int RAM_LOG2_CYCLES = 2,
  parameter int RAM_PINS = 4,
  parameter int ADDR_BITS = 8
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic [RAM_PINS-1:0]                       addr_bits,
  output logic [RAM_PINS-1:0]                       data_bits,
  output logic [RAM_LOG2_CYCLES-1:0]                phase,
  output logic                                      data_valid,
  input  logic                                      we,
  input  logic [ADDR_BITS-1:0]                      waddr,
  input  logic [RAM_PINS*(1<<RAM_LOG2_CYCLES)-1:0]  wdata
);
  localparam int WORD_BITS = RAM_PINS * (1 << RAM_LOG2_CYCLES);
  logic [WORD_BITS-1:0] mem [2**ADDR_BITS];
  logic [WORD_BITS-RAM_PINS-1:0] addr_sr;
  logic [WORD_BITS-1:0] data_word;
  logic [ADDR_BITS-1:0] lookup_addr;
  logic last;
  assign last = &phase;
  // final nibble bypasses the register; upper address bits alias away
  assign lookup_addr = ADDR_BITS'({addr_bits, addr_sr});
  assign data_bits = data_word[phase*RAM_PINS +: RAM_PINS];
  always_ff @(posedge clk) begin
    if (reset) begin
      phase <= '0;
      addr_sr <= '0;
      data_word <= '0;
      data_valid <= 1'b0;
    end else begin
      phase <= phase + 1'b1;
      if (!last) addr_sr[phase*RAM_PINS +: RAM_PINS] <= addr_bits;
      if (last) begin
        data_word <= mem[lookup_addr];
        data_valid <= 1'b1;
      end
    end
  end
  // independent of reset; NBA ordering gives read-before-write on collisions
  always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
endmodule

// File: tb/tb_nibble_ram_responder.sv
// tb_nibble_ram_responder: directed frame-level checks of the nibble RAM responder
module tb_nibble_ram_responder;
  logic clk = 0, reset = 1, we = 0;
  logic [3:0] addr_bits = 0, data_bits;
  logic [1:0] phase;
  logic data_valid;
  logic [7:0] waddr = 0;
  logic [15:0] wdata = 0;
  int errors = 0, checks = 0;

  nibble_ram_responder dut (
    .clk(clk), .reset(reset), .addr_bits(addr_bits), .data_bits(data_bits),
    .phase(phase), .data_valid(data_valid), .we(we), .waddr(waddr), .wdata(wdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // one full frame: send address a, expect word d with valid v; optional write on the lookup edge
  task automatic frame(input string tag, input logic [15:0] a, input logic [15:0] d, input logic v,
                       input logic wr, input logic [7:0] wa, input logic [15:0] wd);
    logic [15:0] aa, dd;
    aa = a;
    dd = d;
    for (int p = 0; p < 4; p++) begin
      addr_bits = aa[p*4 +: 4];
      chk({tag, " phase"}, 16'(phase), 16'(p));
      chk({tag, " data"}, 16'(data_bits), 16'(dd[p*4 +: 4]));
      chk({tag, " valid"}, 16'(data_valid), 16'(v));
      if (p == 3 && wr) begin
        we = 1; waddr = wa; wdata = wd;
      end
      tick();
      we = 0;
    end
  endtask

  initial begin
    logic [15:0] w;
    we = 1; waddr = 8'h12; wdata = 16'hBEEF;
    tick();
    waddr = 8'h34; wdata = 16'h1234;
    tick();
    we = 0;
    chk("rst phase", 16'(phase), 16'h0);
    chk("rst data", 16'(data_bits), 16'h0);
    chk("rst valid", 16'(data_valid), 16'h0);
    reset = 0;
    frame("f1 first", 16'h0012, 16'h0000, 0, 0, 0, 0);
    frame("f2 read12", 16'h0034, 16'hBEEF, 1, 0, 0, 0);
    frame("f3 b2b34", 16'hAB12, 16'h1234, 1, 0, 0, 0);
    frame("f4 alias", 16'h0012, 16'hBEEF, 1, 1, 8'h12, 16'h5555);
    frame("f5 collide", 16'h0012, 16'hBEEF, 1, 0, 0, 0);
    frame("f6 newval", 16'h0034, 16'h5555, 1, 0, 0, 0);
    w = 16'h1234;
    for (int p = 0; p < 2; p++) begin
      addr_bits = 4'hF;
      chk("f7 phase", 16'(phase), 16'(p));
      chk("f7 data", 16'(data_bits), 16'(w[p*4 +: 4]));
      tick();
    end
    chk("f7 phase2", 16'(phase), 16'h2);
    reset = 1;
    tick();
    reset = 0;
    chk("midrst phase", 16'(phase), 16'h0);
    chk("midrst data", 16'(data_bits), 16'h0);
    chk("midrst valid", 16'(data_valid), 16'h0);
    frame("f8 refill", 16'h0034, 16'h0000, 0, 0, 0, 0);
    frame("f9 read34", 16'h0000, 16'h1234, 1, 0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/nibble_ram_responder.md
Name: nibble_ram_responder

Overview:
- Memory-side end of the nibble-serial RAM interface used by the tile renderer and address-sequencer blocks.
- Each frame of 2^RAM_LOG2_CYCLES clock cycles, it receives one address serially on addr_bits, low nibble first.
- It looks the address up in an internal word memory and returns the word serially on data_bits during the following frame, low nibble first.
- Used as a behavioural RAM in benches and as the FPGA-side RAM companion; memory is loaded through a parallel write port.

Parameters:
- RAM_LOG2_CYCLES, 2: log2 of the number of cycles per frame; also the number of nibbles per address and per data word.
- RAM_PINS, 4: width of addr_bits and data_bits.
- ADDR_BITS, 8: number of low address bits decoded; memory depth is 2^ADDR_BITS words.
- Derived: WORD_BITS = RAM_PINS * 2^RAM_LOG2_CYCLES (16 by default). This is both the serial address width and the data word width.

Ports:
- clk, input, 1: clock.
- reset, input, 1: reset, synchronous, active-high.
- addr_bits, input, RAM_PINS: current address nibble from the initiator.
- data_bits, output, RAM_PINS: current data nibble to the initiator.
- phase, output, RAM_LOG2_CYCLES: position within the current frame, 0..2^RAM_LOG2_CYCLES-1.
- data_valid, output, 1: high when data_bits carries a word fetched from a fully received address.
- we, input, 1: write enable.
- waddr, input, ADDR_BITS: write address.
- wdata, input, WORD_BITS: write data.

Behaviour:
- Phase counter
  - Increments by 1 every cycle and wraps from 2^RAM_LOG2_CYCLES-1 to 0.
  - Reset sets it to 0. The initiator is reset in the same cycle, so both ends stay frame-aligned; there is no other synchronisation.
- Address capture
  - On each cycle at phase p, addr_bits is stored into address shift register bits [p*RAM_PINS+RAM_PINS-1 : p*RAM_PINS].
  - The final nibble, captured at the last phase, is taken directly from addr_bits, not from the register.
  - The full address is A = {addr_bits, stored lower nibbles}.
- Lookup
  - At the clock edge that ends the last phase, data word register <= mem[A[ADDR_BITS-1:0]].
  - Address bits at and above ADDR_BITS are ignored, so addresses alias.
- Data return
  - During phase p of the next frame, data_bits = data_word[p*RAM_PINS+RAM_PINS-1 : p*RAM_PINS].
  - This is combinational from registered state only; there is no combinational path from addr_bits to data_bits.
  - Latency: the first data nibble appears exactly 1 cycle after the last address nibble, i.e. one frame after the first address nibble.
- Pipelining: address capture for frame f+1 overlaps data return for frame f. Back-to-back frames are sustained indefinitely with no bubbles.
- data_valid
  - 0 from reset until the first lookup edge.
  - 1 from then on until the next reset.
- Write port
  - When we=1, mem[waddr] <= wdata at the clock edge.
  - Writes are allowed in any phase.
  - Collision: a write to the address being looked up on the same edge is read-before-write, so the lookup latches the old contents and the new value is visible from the next lookup on.
- Reset values
  - phase = 0, address shift register = 0, data word = 0, so data_bits = 0.
  - data_valid = 0.
  - Memory contents are not reset.
- Reset mid-frame
  - The partial address is discarded and the data word is cleared.
  - The next lookup happens after a full new frame.
  - A write asserted during reset is still performed.

Test Plan:
1. Reset held 2 cycles, then released -> phase 0,1,2,3,0; data_bits=0 and data_valid=0 through cycle 3; data_valid=1 from cycle 4.
2. Write mem[0x12]=0xBEEF; send address 0x0012 as nibbles 2,1,0,0 -> next frame data_bits = F,E,E,B.
3. Back-to-back: mem[0x12]=0xBEEF, mem[0x34]=0x1234; addresses 0x0012 then 0x0034 in consecutive frames -> data F,E,E,B immediately followed by 4,3,2,1, no gap.
4. Aliasing: address 0xAB12 -> returns 0xBEEF, same as address 0x0012.
5. Collision: mem[0x12]=0xBEEF, then write 0x5555 to 0x12 on the lookup edge of address 0x12 -> that frame returns 0xBEEF; a repeat lookup of 0x12 returns 0x5555.
6. Reset asserted at phase 2 during the data frame for 0x1234 -> data_bits=0 and data_valid=0 next cycle; phase restarts at 0; a fresh address frame for 0x0034 returns 4,3,2,1 one frame later.
